// File: rtl/id_stage_pkg.sv
// Shared constants, control-word type and main-control decode for the ID stage.
package id_stage_pkg;

    localparam int WORD_W    = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Don't-care fields of sw/beq resolve to 0; unknown opcodes decode as a NOP.
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        // NOTE: defaulting the whole word first guarantees every path assigns every bit, so no latch can be inferred.
        c = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// Architectural register file: one synchronous write port, two combinational
// read ports with write-through, hard-wired zero register.
module id_stage_reg_file
    import id_stage_pkg::*;
#(
    parameter int REGS = 32
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_we,
    input  logic [REG_IDX_W-1:0] i_waddr,
    input  logic [WORD_W-1:0]    i_wdata,
    input  logic [REG_IDX_W-1:0] i_raddr1,
    input  logic [REG_IDX_W-1:0] i_raddr2,
    output logic [WORD_W-1:0]    o_rdata1,
    output logic [WORD_W-1:0]    o_rdata2
);

    logic [WORD_W-1:0] r_regs [REGS];
    logic              w_wr_en;

    assign w_wr_en = i_we && (i_waddr != '0);

    // NOTE: the array is cleared on reset, so it maps to flops rather than a RAM macro; that is what the clear-on-reset behaviour costs.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            for (int i = 0; i < REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Write-through lets writeback and decode share a cycle without a bypass stage.
    assign o_rdata1 = (i_raddr1 == '0)                    ? '0      :
                      (w_wr_en && (i_waddr == i_raddr1))  ? i_wdata :
                                                            r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0)                    ? '0      :
                      (w_wr_en && (i_waddr == i_raddr2))  ? i_wdata :
                                                            r_regs[i_raddr2];

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: field split, main control, sign extension,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int          REGS      = 32,
    parameter logic [31:0] RESET_NPC = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] nPC_id,
    input  logic [31:0] IR_id,
    input  logic        RegWrite_wb,
    input  logic [4:0]  WriteReg_wb,
    input  logic [31:0] WriteData_wb,
    output logic        stall,
    output logic [31:0] nPC_ex,
    output logic [31:0] rd1_ex,
    output logic [31:0] rd2_ex,
    output logic [31:0] imm_ex,
    output logic [4:0]  rs_ex,
    output logic [4:0]  rt_ex,
    output logic [4:0]  rd_ex,
    output logic        RegDst_ex,
    output logic        ALUSrc_ex,
    output logic        MemRead_ex,
    output logic        MemWrite_ex,
    output logic        MemtoReg_ex,
    output logic        RegWrite_ex,
    output logic        Branch_ex,
    output logic [1:0]  ALUOp_ex
);

    logic [5:0]        w_opcode;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [WORD_W-1:0] w_imm;
    logic [WORD_W-1:0] w_rd1;
    logic [WORD_W-1:0] w_rd2;
    ctrl_t             w_ctrl;

    logic [WORD_W-1:0] r_npc;
    logic [WORD_W-1:0] r_rd1;
    logic [WORD_W-1:0] r_rd2;
    logic [WORD_W-1:0] r_imm;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_rd;
    ctrl_t             r_ctrl;

    assign w_opcode = IR_id[31:26];
    assign w_rs     = IR_id[25:21];
    assign w_rt     = IR_id[20:16];
    assign w_rd     = IR_id[15:11];
    assign w_imm    = {{16{IR_id[15]}}, IR_id[15:0]};
    assign w_ctrl   = decode_ctrl(w_opcode);

    id_stage_reg_file #(
        .REGS (REGS)
    ) u_reg_file (
        .clk      (clk),
        .i_reset  (reset),
        .i_we     (RegWrite_wb),
        .i_waddr  (WriteReg_wb),
        .i_wdata  (WriteData_wb),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_rt),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2)
    );

    // Conservative: any instruction naming the load's rt waits, even if it only writes it.
    assign stall = r_ctrl.mem_read && (r_rt != '0) && ((r_rt == w_rs) || (r_rt == w_rt));

    // NOTE: non-blocking assignments keep every ID/EX field sampling pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || stall) begin
            r_npc  <= RESET_NPC;
            r_rd1  <= '0;
            r_rd2  <= '0;
            r_imm  <= '0;
            r_rs   <= '0;
            r_rt   <= '0;
            r_rd   <= '0;
            r_ctrl <= CTRL_NOP;
        end else begin
            r_npc  <= nPC_id;
            r_rd1  <= w_rd1;
            r_rd2  <= w_rd2;
            r_imm  <= w_imm;
            r_rs   <= w_rs;
            r_rt   <= w_rt;
            r_rd   <= w_rd;
            r_ctrl <= w_ctrl;
        end
    end

    assign nPC_ex      = r_npc;
    assign rd1_ex      = r_rd1;
    assign rd2_ex      = r_rd2;
    assign imm_ex      = r_imm;
    assign rs_ex       = r_rs;
    assign rt_ex       = r_rt;
    assign rd_ex       = r_rd;
    assign RegDst_ex   = r_ctrl.reg_dst;
    assign ALUSrc_ex   = r_ctrl.alu_src;
    assign MemtoReg_ex = r_ctrl.mem_to_reg;
    assign RegWrite_ex = r_ctrl.reg_write;
    assign MemRead_ex  = r_ctrl.mem_read;
    assign MemWrite_ex = r_ctrl.mem_write;
    assign Branch_ex   = r_ctrl.branch;
    assign ALUOp_ex    = r_ctrl.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: reference model, decode table, hand-written
// hazard/reset sequences and randomized traffic.
module tb_id_stage;

    localparam logic [31:0] RST_NPC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] nPC_id, IR_id, WriteData_wb;
    logic        RegWrite_wb;
    logic [4:0]  WriteReg_wb;
    logic        stall;
    logic [31:0] nPC_ex, rd1_ex, rd2_ex, imm_ex;
    logic [4:0]  rs_ex, rt_ex, rd_ex;
    logic        RegDst_ex, ALUSrc_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, RegWrite_ex, Branch_ex;
    logic [1:0]  ALUOp_ex;

    id_stage #(.REGS(32), .RESET_NPC(RST_NPC)) dut (
        .clk(clk), .reset(reset), .nPC_id(nPC_id), .IR_id(IR_id),
        .RegWrite_wb(RegWrite_wb), .WriteReg_wb(WriteReg_wb), .WriteData_wb(WriteData_wb),
        .stall(stall), .nPC_ex(nPC_ex), .rd1_ex(rd1_ex), .rd2_ex(rd2_ex), .imm_ex(imm_ex),
        .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
        .RegDst_ex(RegDst_ex), .ALUSrc_ex(ALUSrc_ex), .MemRead_ex(MemRead_ex),
        .MemWrite_ex(MemWrite_ex), .MemtoReg_ex(MemtoReg_ex), .RegWrite_ex(RegWrite_ex),
        .Branch_ex(Branch_ex), .ALUOp_ex(ALUOp_ex)
    );

    always #5 clk = ~clk;

    // Control word order: {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}
    typedef struct packed {
        logic [31:0] npc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [8:0]  ctrl;
    } ex_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [8:0]  ctrl;
        logic [31:0] imm;
        logic [14:0] fld;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_regs [32];
    ex_t         m_ex;
    logic        last_stall;
    vec_t        tbl [6];

    function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 9'b1_0_0_1_0_0_0_10;
            6'h23:   return 9'b0_1_1_1_1_0_0_00;
            6'h2B:   return 9'b0_1_0_0_0_1_0_00;
            6'h04:   return 9'b0_0_0_0_0_0_1_01;
            6'h08:   return 9'b0_1_0_1_0_0_0_00;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [8:0] dut_ctrl();
        return {RegDst_ex, ALUSrc_ex, MemtoReg_ex, RegWrite_ex, MemRead_ex,
                MemWrite_ex, Branch_ex, ALUOp_ex};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        check("nPC_ex", nPC_ex, m_ex.npc);
        check("rd1_ex", rd1_ex, m_ex.rd1);
        check("rd2_ex", rd2_ex, m_ex.rd2);
        check("imm_ex", imm_ex, m_ex.imm);
        check("fields", {17'd0, rs_ex, rt_ex, rd_ex}, {17'd0, m_ex.rs, m_ex.rt, m_ex.rd});
        check("ctrl", {23'd0, dut_ctrl()}, {23'd0, m_ex.ctrl});
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (idx == 0)                   return 32'd0;
        if (we && wa != 0 && wa == idx) return wd;
        return m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_ex     = '0;
        m_ex.npc = RST_NPC;
    endtask

    // One clock: drive inputs, check stall before the edge, then all ID/EX outputs after it.
    task automatic cycle(input logic rst, input logic [31:0] npc, input logic [31:0] ir,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic exp_stall;
        ex_t  nxt;
        @(negedge clk);
        reset = rst; nPC_id = npc; IR_id = ir;
        RegWrite_wb = we; WriteReg_wb = wa; WriteData_wb = wd;
        #1;
        exp_stall = m_ex.ctrl[4] && (m_ex.rt != 0) &&
                    ((m_ex.rt == ir[25:21]) || (m_ex.rt == ir[20:16]));
        last_stall = stall;
        check("stall", {31'd0, stall}, {31'd0, exp_stall});
        nxt     = '0;
        nxt.npc = RST_NPC;
        if (!rst && !exp_stall) begin
            nxt.npc  = npc;
            nxt.rd1  = ref_read(ir[25:21], we, wa, wd);
            nxt.rd2  = ref_read(ir[20:16], we, wa, wd);
            nxt.imm  = {{16{ir[15]}}, ir[15:0]};
            nxt.rs   = ir[25:21];
            nxt.rt   = ir[20:16];
            nxt.rd   = ir[15:11];
            nxt.ctrl = ref_ctrl(ir[31:26]);
        end
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else if (we && wa != 0) m_regs[wa] = wd;
        m_ex = nxt;
        compare_all();
    endtask

    initial begin
        logic [31:0] ir, held_ir;
        logic [5:0]  ops [6];

        tbl[0] = '{ir: 32'h00A01820, ctrl: 9'b100100010, imm: 32'h00001820, fld: {5'd5, 5'd0, 5'd3}};
        tbl[1] = '{ir: 32'h8C220000, ctrl: 9'b011110000, imm: 32'h00000000, fld: {5'd1, 5'd2, 5'd0}};
        tbl[2] = '{ir: 32'hACE60004, ctrl: 9'b010001000, imm: 32'h00000004, fld: {5'd7, 5'd6, 5'd0}};
        tbl[3] = '{ir: 32'h1022FFFF, ctrl: 9'b000000101, imm: 32'hFFFFFFFF, fld: {5'd1, 5'd2, 5'd31}};
        tbl[4] = '{ir: 32'h20E8FFFC, ctrl: 9'b010100000, imm: 32'hFFFFFFFC, fld: {5'd7, 5'd8, 5'd31}};
        tbl[5] = '{ir: 32'hFC000000, ctrl: 9'b000000000, imm: 32'h00000000, fld: {5'd0, 5'd0, 5'd0}};
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};

        // Reset held for two edges.
        reset = 1'b1; nPC_id = 32'd0; IR_id = 32'd0;
        RegWrite_wb = 1'b0; WriteReg_wb = 5'd0; WriteData_wb = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        check("stall_after_reset", {31'd0, stall}, 32'd0);

        // Every register reads zero after reset.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 32'd0, {6'h00, 5'(2 * i), 5'(2 * i + 1), 16'd0}, 1'b0, 5'd0, 32'd0);
            check("zero_rd1", rd1_ex, 32'd0);
            check("zero_rd2", rd2_ex, 32'd0);
        end

        // Writeback then read.
        cycle(1'b0, 32'd4, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        cycle(1'b0, 32'd8, 32'h00A01820, 1'b0, 5'd0, 32'd0);
        check("t2_rd1", rd1_ex, 32'hDEADBEEF);
        check("t2_rd2", rd2_ex, 32'd0);
        check("t2_rd", {27'd0, rd_ex}, 32'd3);
        check("t2_ctl", {29'd0, RegDst_ex, RegWrite_ex, ALUOp_ex == 2'b10}, 32'd7);

        // Write-through in the decode cycle.
        cycle(1'b0, 32'd12, 32'h20E8FFFC, 1'b1, 5'd7, 32'h00001234);
        check("t3_rd1", rd1_ex, 32'h00001234);
        check("t3_imm", imm_ex, 32'hFFFFFFFC);
        check("t3_alusrc", {31'd0, ALUSrc_ex}, 32'd1);

        // Register 0 ignores writes, including a same-cycle write-through attempt.
        cycle(1'b0, 32'd16, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        cycle(1'b0, 32'd20, 32'h00001820, 1'b1, 5'd0, 32'hFFFFFFFF);
        check("t4_r0", rd1_ex, 32'd0);
        cycle(1'b0, 32'd20, 32'h00001820, 1'b0, 5'd0, 32'd0);
        check("t4_r0_later", rd1_ex, 32'd0);

        // Decode table.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 32'h100 + 32'(i * 4), tbl[i].ir, 1'b0, 5'd0, 32'd0);
            check("tbl_ctrl", {23'd0, dut_ctrl()}, {23'd0, tbl[i].ctrl});
            check("tbl_imm", imm_ex, tbl[i].imm);
            check("tbl_fld", {17'd0, rs_ex, rt_ex, rd_ex}, {17'd0, tbl[i].fld});
            check("tbl_npc", nPC_ex, 32'h100 + 32'(i * 4));
        end

        // Load-use: one bubble, then the held add proceeds.
        cycle(1'b0, 32'h20, 32'h8C220000, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, 32'h24, 32'h00432020, 1'b0, 5'd0, 32'd0);
        check("lu_stall", {31'd0, last_stall}, 32'd1);
        check("lu_bubble_ctrl", {23'd0, dut_ctrl()}, 32'd0);
        check("lu_bubble_npc", nPC_ex, RST_NPC);
        cycle(1'b0, 32'h24, 32'h00432020, 1'b0, 5'd0, 32'd0);
        check("lu_release", {31'd0, last_stall}, 32'd0);
        check("lu_rs", {27'd0, rs_ex}, 32'd2);
        check("lu_ctrl", {23'd0, dut_ctrl()}, 32'h122);

        // lw into $0 never stalls.
        cycle(1'b0, 32'h28, 32'h8C200000, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, 32'h2C, 32'h00002020, 1'b0, 5'd0, 32'd0);
        check("lw0_nostall", {31'd0, last_stall}, 32'd0);

        // Reset while a stall is pending.
        cycle(1'b0, 32'h30, 32'h8C220000, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, 32'h34, 32'h00432020, 1'b1, 5'd9, 32'h55);
        check("rs_stall_seen", {31'd0, last_stall}, 32'd1);
        check("rs_npc", nPC_ex, RST_NPC);
        check("rs_ctrl", {23'd0, dut_ctrl()}, 32'd0);
        cycle(1'b0, 32'h34, 32'h00432020, 1'b0, 5'd0, 32'd0);
        check("rs_stall_drop", {31'd0, last_stall}, 32'd0);

        // Randomized traffic; IF/ID holds its instruction while stalled.
        held_ir = 32'd0;
        for (int n = 0; n < 400; n++) begin
            if (last_stall) begin
                ir = held_ir;
            end else begin
                ir = $urandom;
                ir[31:26] = ops[$urandom_range(0, 5)];
                ir[25:21] = 5'($urandom_range(0, 3));
                ir[20:16] = 5'($urandom_range(0, 3));
            end
            held_ir = ir;
            cycle($urandom_range(0, 63) == 0, $urandom, ir, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
